sram_like_responder: RTL and testbench

Slave-side model of the sram-like bus that the CPU datapath drives on its instruction and data ports: it accepts `req`/`addr_ok` address handshakes and returns `data_ok`/`rdata` responses. It is backed by an internal word-organised memory with fixed, parameterised response latency and bounded outstanding transactions. One instance serves the instruction port and one the data port in simulation and FPGA bring-up, replacing the external AXI bridge until that bridge exists.

---
 rtl/sram_like_responder.sv | 104 ++++++++++
 tb/tb_sram_like_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// Slave side of the sram-like bus: word memory behind an addr_ok/data_ok handshake,
// answering every accepted transaction in order after a fixed LATENCY.
module sram_like_responder #(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_addr_ok,
  output logic        o_data_ok,
  output logic [31:0] o_rdata
);

  localparam int unsigned Words = 1 << ADDR_W;
  localparam int unsigned PtrW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);
  localparam logic [2:0]      InitCd  = 3'(LATENCY - 1);

  logic [31:0]     r_mem [Words];
  logic [31:0]     r_q_data [MAX_OUTSTANDING];
  logic [2:0]      r_q_cd [MAX_OUTSTANDING];
  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_count;

  logic [ADDR_W-1:0] w_idx;
  logic [3:0]        w_be;
  logic              w_accept;
  logic              w_retire;
  logic [CntW-1:0]   w_count_next;
  logic              w_unused_addr;

  assign w_idx         = i_addr[ADDR_W+1:2];
  assign w_unused_addr = ^i_addr[31:ADDR_W+2];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Misaligned halfword/word accesses still get a response but enable no lanes.
  always_comb begin
    w_be = 4'b0000;
    unique case (i_size)
      2'b00:   w_be = 4'b0001 << i_addr[1:0];
      2'b01:   w_be = i_addr[0] ? 4'b0000 : (i_addr[1] ? 4'b1100 : 4'b0011);
      default: w_be = (i_addr[1:0] != 2'b00) ? 4'b0000 : 4'b1111;
    endcase
  end

  // A retiring head frees its slot for an acceptance in the same cycle.
  always_comb begin
    w_retire  = (r_count != '0) && (r_q_cd[r_head] == 3'd0);
    o_addr_ok = i_req & i_rstn & ((r_count < MaxCnt) | w_retire);
    w_accept  = o_addr_ok;
    o_data_ok = w_retire;
    o_rdata   = w_retire ? r_q_data[r_head] : 32'h0;
  end

  always_comb begin
    w_count_next = r_count;
    unique case ({w_accept, w_retire})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (r_q_cd[i] != 3'd0) r_q_cd[i] <= r_q_cd[i] - 3'd1;
      end
      if (w_accept) begin
        r_q_data[r_tail] <= i_wr ? 32'h0 : r_mem[w_idx];
        r_q_cd[r_tail]   <= InitCd;
        r_tail           <= ptr_inc(r_tail);
      end
      if (w_retire) r_head <= ptr_inc(r_head);
      r_count <= w_count_next;
    end
  end

  // Memory is deliberately left out of reset so contents survive it.
  always_ff @(posedge i_clk) begin
    if (w_accept && i_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: three parameterisations, each checked every cycle against
// a queue-based model, plus directed literal checks of lanes, back-pressure and reset.
module tb_sram_like_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned AW    = (g == 0) ? 10 : 4;
    localparam int unsigned L     = (g == 0) ? 2 : ((g == 1) ? 4 : 5);
    localparam int unsigned M     = (g == 1) ? 2 : 4;
    localparam int unsigned Words = 1 << AW;

    logic        rstn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    int          phase;

    sram_like_responder #(
      .ADDR_W         (AW),
      .LATENCY        (L),
      .MAX_OUTSTANDING(M)
    ) u_dut (
      .i_clk    (clk),
      .i_rstn   (rstn),
      .i_req    (req),
      .i_wr     (wr),
      .i_size   (size),
      .i_addr   (addr),
      .i_wdata  (wdata),
      .o_addr_ok(addr_ok),
      .o_data_ok(data_ok),
      .o_rdata  (rdata)
    );

    // Model: memory array plus FIFO of (due cycle, response data).
    logic [31:0] m_mem [Words];
    int          m_due [$];
    logic [31:0] m_dat [$];
    int          cyc = 0;
    bit          started = 1'b0;

    initial begin : p_model
      bit retire;
      bit accept;
      int widx;
      int off;
      int nb;
      forever begin
        @(posedge clk);
        if (!rstn) begin
          m_due.delete();
          m_dat.delete();
        end else begin
          retire = (m_due.size() > 0) && (m_due[0] == cyc);
          accept = req && (retire || m_due.size() < int'(M));
          if (retire) begin
            void'(m_due.pop_front());
            void'(m_dat.pop_front());
          end
          if (accept) begin
            widx = int'(addr[AW+1:2]);
            if (wr) begin
              off = int'(addr[1:0]);
              nb  = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
              if (off % nb == 0) begin
                for (int k = 0; k < nb; k++) m_mem[widx][8*(off+k) +: 8] = wdata[8*(off+k) +: 8];
              end
              m_dat.push_back(32'h0);
            end else begin
              m_dat.push_back(m_mem[widx]);
            end
            m_due.push_back(cyc + int'(L));
          end
        end
        cyc++;
        started = 1'b1;
      end
    end

    initial begin : p_compare
      bit edok;
      forever begin
        @(negedge clk);
        if (started) begin
          edok = (m_due.size() > 0) && (m_due[0] == cyc);
          check($sformatf("i%0d cyc%0d data_ok", g, cyc), data_ok, edok);
          check($sformatf("i%0d cyc%0d rdata", g, cyc), rdata, edok ? m_dat[0] : 32'h0);
          check($sformatf("i%0d cyc%0d addr_ok", g, cyc), addr_ok,
                rstn && req && (edok || m_due.size() < int'(M)));
        end
      end
    end

    task automatic wait_cycles(input int n);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    endtask

    // Holds req until accepted; returns one cycle after the accepting edge.
    task automatic xfer(input bit w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d);
      bit acc;
      acc = 1'b0;
      req = 1'b1; wr = w; size = s; addr = a; wdata = d;
      for (int t = 0; t < 40 && !acc; t++) begin
        @(negedge clk);
        acc = addr_ok;
        @(posedge clk);
        #1;
      end
      req = 1'b0;
      check($sformatf("i%0d accept of %h", g, a), acc, 1);
    endtask

    initial begin : p_drive
      rstn = 1'b0; req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0; wdata = 32'h0;
      phase = 0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check($sformatf("i%0d reset addr_ok", g), addr_ok, 0);
      check($sformatf("i%0d reset data_ok", g), data_ok, 0);
      check($sformatf("i%0d reset rdata", g), rdata, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1; req = 1'b0;
      repeat (2) begin
        @(negedge clk);
        check($sformatf("i%0d idle addr_ok", g), addr_ok, 0);
        check($sformatf("i%0d idle data_ok", g), data_ok, 0);
        check($sformatf("i%0d idle rdata", g), rdata, 0);
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < int'(Words); i++) xfer(1'b1, 2'd2, 32'(i) << 2, $urandom());
      wait_cycles(12);
      phase = 1;
      wait (phase == 2);
      for (int k = 0; k < 400; k++) begin
        rstn  = ($urandom_range(0, 39) != 0);
        req   = ($urandom_range(0, 9) < 8);
        wr    = 1'($urandom_range(0, 1));
        size  = 2'($urandom_range(0, 3));
        addr  = $urandom();
        wdata = $urandom();
        @(posedge clk);
        #1;
      end
      rstn = 1'b1; req = 1'b0;
      wait_cycles(12);
      n_done++;
    end

    if (g == 0) begin : g_dir_lanes
      initial begin : p_dir
        wait (phase == 1);
        xfer(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
        xfer(1'b0, 2'd2, 32'h100, 32'h0);
        @(negedge clk);
        check("i0 write pulse data_ok", data_ok, 1);
        check("i0 write pulse rdata", rdata, 32'h0);
        wait_cycles(1);
        @(negedge clk);
        check("i0 read-after-write data_ok", data_ok, 1);
        check("i0 read-after-write rdata", rdata, 32'hDEADBEEF);
        wait_cycles(1);
        @(negedge clk);
        check("i0 pulse ends", data_ok, 0);
        wait_cycles(1);
        xfer(1'b1, 2'd2, 32'h200, 32'h00000000);
        xfer(1'b1, 2'd0, 32'h201, 32'h0000AB00);
        xfer(1'b1, 2'd1, 32'h202, 32'h56780000);
        xfer(1'b0, 2'd2, 32'h200, 32'h0);
        wait_cycles(1);
        @(negedge clk);
        check("i0 byte/half lanes", rdata, 32'h5678AB00);
        wait_cycles(1);
        xfer(1'b1, 2'd2, 32'h203, 32'hFFFFFFFF);
        xfer(1'b0, 2'd2, 32'h200, 32'h0);
        @(negedge clk);
        check("i0 misaligned write data_ok", data_ok, 1);
        wait_cycles(1);
        @(negedge clk);
        check("i0 misaligned write ignored", rdata, 32'h5678AB00);
        wait_cycles(6);
        phase = 2;
      end
    end else if (g == 1) begin : g_dir_backpressure
      initial begin : p_dir
        logic [9:0] aok_pat;
        logic [9:0] dok_pat;
        wait (phase == 1);
        aok_pat = 10'b1100110011;
        dok_pat = 10'b1100110000;
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h40;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check($sformatf("i1 backpressure addr_ok k=%0d", k), addr_ok, aok_pat[k]);
          check($sformatf("i1 backpressure data_ok k=%0d", k), data_ok, dok_pat[k]);
          @(posedge clk);
          #1;
        end
        req = 1'b0;
        wait_cycles(8);
        phase = 2;
      end
    end else begin : g_dir_reset
      initial begin : p_dir
        logic [4:0] aok_pat;
        wait (phase == 1);
        aok_pat = 5'b01111;
        xfer(1'b0, 2'd2, 32'h4, 32'h0);
        xfer(1'b0, 2'd2, 32'h8, 32'h0);
        xfer(1'b0, 2'd2, 32'hC, 32'h0);
        rstn = 1'b0;
        @(negedge clk);
        check("i2 data_ok in reset", data_ok, 0);
        wait_cycles(1);
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check($sformatf("i2 flushed data_ok k=%0d", k), data_ok, 0);
          @(posedge clk);
          #1;
        end
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h10;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check($sformatf("i2 post-reset addr_ok k=%0d", k), addr_ok, aok_pat[k]);
          @(posedge clk);
          #1;
        end
        req = 1'b0;
        wait_cycles(10);
        phase = 2;
      end
    end
  end

  initial begin : p_top
    for (int t = 0; t < 20000 && n_done < 3; t++) @(posedge clk);
    if (n_done < 3) begin
      n_checks++;
      $display("FAIL run completion: %0d instances finished, expected 3", n_done);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
